// File: rtl/adc_spi_pkg.sv
// Shared constants and types for the DE0-Nano ADC SPI responder.
package adc_spi_pkg;

    localparam int FRAME_BITS      = 16;
    localparam int ADDR_FIRST_EDGE = 3;
    localparam int ADDR_LAST_EDGE  = 5;
    localparam int DATA_LOAD_FALL  = 4;
    localparam int ADC_RES         = 12;

    typedef logic [ADC_RES-1:0] adc_word_t;
    typedef logic [2:0]         adc_chan_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } resp_state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pins between the ADC master and the emulated ADC responder.
interface adc_spi_responder_if;

    logic adc_chip_enable;  // active-low chip select
    logic adc_serial_clk;   // SCLK, idle low
    logic mosi;             // DIN
    logic miso;             // DOUT

    modport master (output adc_chip_enable, adc_serial_clk, mosi, input miso);
    modport slave  (input adc_chip_enable, adc_serial_clk, mosi, output miso);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall strobes derived from the synchronized level.
module spi_sync_edge #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: non-blocking assignments make each stage take the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulated 8-channel 12-bit serial ADC (16-clock frames, address on DIN edges 3..5).
// Define ADC_RESP_TRISTATE_EN to float miso while the responder is deselected.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_CH      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock_in,
    input  logic                         reset,
    adc_spi_responder_if.slave           spi,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_value,
    output logic [ADDR_W-1:0]            addr_captured,
    output logic                         frame_done
);

    logic cs_n_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    resp_state_t              state;
    logic [3:0]               bit_cnt;
    logic [ADDR_W-1:0]        addr_sh;
    logic [ADDR_W-1:0]        cur_ch;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic                     miso_q;
    logic [4:0]               rise_num;
    logic [DATA_WIDTH-1:0]    cur_word;
    logic                     unused;

    // Chip select resets to the deselected level so reset never looks like a frame start.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clock_in), .rst_n(reset), .din(spi.adc_chip_enable),
        .sync(cs_n_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clock_in), .rst_n(reset), .din(spi.adc_serial_clk),
        .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain[0] <= spi.mosi;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_chain[i] <= mosi_chain[i-1];
        end
    end

    assign mosi_s   = mosi_chain[SYNC_STAGES-1];
    assign unused   = &{1'b0, cs_rise, sclk_s};
    assign rise_num = {1'b0, bit_cnt} + 5'd1;
    assign cur_word = ch_value[int'(cur_ch)*DATA_WIDTH +: DATA_WIDTH];

    // bit_cnt holds the number of rising edges seen so far in the current frame.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            addr_sh       <= '0;
            cur_ch        <= '0;
            shift_q       <= '0;
            miso_q        <= 1'b0;
            addr_captured <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    addr_sh <= '0;
                    cur_ch  <= '0;
                    shift_q <= '0;
                    miso_q  <= 1'b0;
                    if (cs_fall) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // Deselect takes priority over any SCLK edge in the same cycle.
                    if (cs_n_s) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        addr_sh <= '0;
                        cur_ch  <= '0;
                        shift_q <= '0;
                        miso_q  <= 1'b0;
                    end else if (sclk_rise) begin
                        if (rise_num >= 5'(ADDR_FIRST_EDGE) && rise_num <= 5'(ADDR_LAST_EDGE))
                            addr_sh <= {addr_sh[ADDR_W-2:0], mosi_s};
                        if (rise_num == 5'(FRAME_BITS)) begin
                            bit_cnt       <= '0;
                            cur_ch        <= addr_sh;
                            addr_captured <= addr_sh;
                            frame_done    <= 1'b1;
                        end else begin
                            bit_cnt <= rise_num[3:0];
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt == 4'(DATA_LOAD_FALL)) begin
                            miso_q  <= cur_word[DATA_WIDTH-1];
                            shift_q <= cur_word << 1;
                        end else if (bit_cnt > 4'(DATA_LOAD_FALL)) begin
                            miso_q  <= shift_q[DATA_WIDTH-1];
                            shift_q <= shift_q << 1;
                        end else begin
                            miso_q <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADC_RESP_TRISTATE_EN
    assign spi.miso = cs_n_s ? 1'bz : miso_q;
`else
    assign spi.miso = miso_q;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench: bit-banged SPI master against a frame-level ADC model.
module tb_adc_spi_responder;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [95:0] ch_value;
    logic [2:0]  addr_captured;
    logic        frame_done;

    int checks   = 0;
    int errors   = 0;
    int fd_cnt   = 0;
    int prev_ch  = 0;
    int exp_addr = 0;

`ifdef ADC_RESP_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    adc_spi_responder_if spi ();

    adc_spi_responder dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .spi           (spi),
        .ch_value      (ch_value),
        .addr_captured (addr_captured),
        .frame_done    (frame_done)
    );

    always #10 clock_in = ~clock_in;

    always @(posedge clock_in) if (frame_done === 1'b1) fd_cnt++;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    // Reference: a frame returns four zeros then the value of the previously addressed channel.
    function automatic logic [15:0] exp_frame(input int ch);
        return {4'h0, ch_value[ch*12 +: 12]};
    endfunction

    task automatic set_ch(input int n, input logic [11:0] v);
        ch_value[n*12 +: 12] = v;
    endtask

    task automatic cs_select();
        spi.adc_chip_enable = 1'b0;
        prev_ch = 0;
        wait_neg(6);
    endtask

    task automatic cs_deselect();
        spi.adc_chip_enable = 1'b1;
        prev_ch = 0;
        wait_neg(6);
    endtask

    // Master: mosi set while SCLK low, miso sampled just before each rise.
    // early[15-k] holds miso three cycles after falling edge k.
    task automatic spi_xfer(input logic [2:0] addr, input int half, input int nbits,
                            input int chg_k, input logic [95:0] chg_val,
                            output logic [15:0] rx, output logic [15:0] early);
        rx = '0;
        early = '0;
        for (int k = 1; k <= nbits; k++) begin
            spi.mosi = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom);
            wait_neg(k == 1 ? half : half - 3);
            rx[16-k] = spi.miso;
            if (k == 1) early[15] = spi.miso;
            spi.adc_serial_clk = 1'b1;
            wait_neg(half);
            spi.adc_serial_clk = 1'b0;
            wait_neg(3);
            if (k < 16) early[15-k] = spi.miso;
            if (k == chg_k) ch_value = chg_val;
        end
        if (nbits == 16) begin
            prev_ch  = int'(addr);
            exp_addr = int'(addr);
        end
    endtask

    task automatic test_reset();
        logic [15:0] rx, early, exp;
        checks++;
        if (addr_captured !== 3'd0 || frame_done !== 1'b0 || spi.miso !== IDLE_MISO) begin
            errors++;
            $display("FAIL reset_state: addr=%0d fd=%b miso=%b, want 0 0 %b",
                     addr_captured, frame_done, spi.miso, IDLE_MISO);
        end
        cs_select();
        spi_xfer(3'd6, 16, 16, 0, ch_value, rx, early);
        spi_xfer(3'd2, 16, 4, 0, ch_value, rx, early);
        reset = 1'b0;
        wait_neg(1);
        checks++;
        if (addr_captured !== 3'd0 || frame_done !== 1'b0 || spi.miso !== IDLE_MISO) begin
            errors++;
            $display("FAIL reset_midframe: addr=%0d fd=%b miso=%b, want 0 0 %b",
                     addr_captured, frame_done, spi.miso, IDLE_MISO);
        end
        spi.adc_chip_enable = 1'b1;
        wait_neg(2);
        reset = 1'b1;
        exp_addr = 0;
        wait_neg(4);
        cs_select();
        exp = exp_frame(prev_ch);
        spi_xfer(3'd1, 16, 16, 0, ch_value, rx, early);
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL reset_restart_frame: got %h want %h", rx, exp);
        end
        cs_deselect();
    endtask

    task automatic test_addr_pipeline();
        logic [15:0] rx, early;
        set_ch(0, 12'hA5C);
        set_ch(5, 12'h3F1);
        cs_select();
        spi_xfer(3'd5, 16, 16, 0, ch_value, rx, early);
        checks++;
        if (rx !== 16'h0A5C) begin
            errors++;
            $display("FAIL pipe_frame1: got %h want 0a5c", rx);
        end
        checks++;
        if (addr_captured !== 3'd5) begin
            errors++;
            $display("FAIL pipe_addr: got %0d want 5", addr_captured);
        end
        spi_xfer(3'($urandom), 16, 16, 0, ch_value, rx, early);
        checks++;
        if (rx !== 16'h03F1) begin
            errors++;
            $display("FAIL pipe_frame2: got %h want 03f1", rx);
        end
        cs_deselect();
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx, early, exp;
        int fd0;
        for (int n = 0; n < 8; n++) set_ch(n, 12'(n * 12'h111));
        cs_select();
        fd0 = fd_cnt;
        for (int a = 0; a < 9; a++) begin
            exp = exp_frame(prev_ch);
            spi_xfer(3'(a % 8), 16, 16, 0, ch_value, rx, early);
            checks++;
            if (rx !== exp) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h want %h", a, rx, exp);
            end
        end
        checks++;
        if (fd_cnt - fd0 !== 9) begin
            errors++;
            $display("FAIL b2b_frame_done_count: got %0d want 9", fd_cnt - fd0);
        end
        cs_deselect();
    endtask

    task automatic test_abort();
        logic [15:0] rx, early, exp;
        int fd0;
        for (int n = 0; n < 8; n++) set_ch(n, 12'($urandom));
        cs_select();
        spi_xfer(3'd3, 16, 16, 0, ch_value, rx, early);
        fd0 = fd_cnt;
        spi_xfer(3'b110, 16, 4, 0, ch_value, rx, early);
        cs_deselect();
        checks++;
        if (fd_cnt !== fd0 || addr_captured !== 3'(exp_addr)) begin
            errors++;
            $display("FAIL abort_state: fd_delta=%0d addr=%0d, want 0 %0d",
                     fd_cnt - fd0, addr_captured, exp_addr);
        end
        checks++;
        if (spi.miso !== IDLE_MISO) begin
            errors++;
            $display("FAIL abort_miso_idle: got %b want %b", spi.miso, IDLE_MISO);
        end
        // SCLK activity while deselected must not advance anything.
        repeat (5) begin
            spi.adc_serial_clk = 1'b1;
            wait_neg(8);
            spi.adc_serial_clk = 1'b0;
            wait_neg(8);
        end
        cs_select();
        exp = exp_frame(prev_ch);
        spi_xfer(3'd4, 16, 16, 0, ch_value, rx, early);
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL abort_next_ch0: got %h want %h", rx, exp);
        end
        cs_deselect();
    endtask

    task automatic test_value_change();
        logic [15:0] rx, early;
        logic [95:0] nv;
        set_ch(0, 12'h000);
        nv = ch_value;
        nv[11:0] = 12'hFFF;
        cs_select();
        spi_xfer(3'd0, 16, 16, 4, nv, rx, early);
        checks++;
        if (rx !== 16'h0000) begin
            errors++;
            $display("FAIL change_current: got %h want 0000", rx);
        end
        spi_xfer(3'd0, 16, 16, 0, ch_value, rx, early);
        checks++;
        if (rx !== 16'h0FFF) begin
            errors++;
            $display("FAIL change_next: got %h want 0fff", rx);
        end
        cs_deselect();
    endtask

    task automatic test_fast();
        logic [15:0] rx, early, exp;
        for (int n = 0; n < 8; n++) set_ch(n, 12'($urandom));
        cs_select();
        for (int f = 0; f < 6; f++) begin
            exp = exp_frame(prev_ch);
            spi_xfer(3'($urandom), 4, 16, 0, ch_value, rx, early);
            checks++;
            if (rx !== exp) begin
                errors++;
                $display("FAIL fast_frame%0d: got %h want %h", f, rx, exp);
            end
            checks++;
            if (early !== exp) begin
                errors++;
                $display("FAIL fast_latency%0d: got %h want %h", f, early, exp);
            end
        end
        cs_deselect();
    endtask

    task automatic test_random();
        logic [15:0] rx, early, exp;
        for (int s = 0; s < 4; s++) begin
            cs_select();
            for (int f = 0; f < 4; f++) begin
                for (int n = 0; n < 8; n++) set_ch(n, 12'($urandom));
                exp = exp_frame(prev_ch);
                spi_xfer(3'($urandom), int'($urandom_range(4, 20)), 16, 0, ch_value, rx, early);
                checks++;
                if (rx !== exp || addr_captured !== 3'(exp_addr)) begin
                    errors++;
                    $display("FAIL random_s%0d_f%0d: got %h/%0d want %h/%0d",
                             s, f, rx, addr_captured, exp, exp_addr);
                end
            end
            cs_deselect();
        end
    endtask

    initial begin
        reset = 1'b0;
        spi.adc_chip_enable = 1'b1;
        spi.adc_serial_clk  = 1'b0;
        spi.mosi            = 1'b0;
        for (int n = 0; n < 8; n++) set_ch(n, 12'($urandom));
        wait_neg(3);
        reset = 1'b1;
        wait_neg(2);
        test_reset();
        test_addr_pipeline();
        test_back_to_back();
        test_abort();
        test_value_change();
        test_fast();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
Synthesizable SPI responder that emulates the DE0-Nano 8-channel, 12-bit serial ADC (16-clock frame, 3-bit address on DIN, MSB-first data on DOUT).
- Sits on the far end of our ADC SPI master: takes chip select, SCLK and MOSI, and drives MISO.
- Channel values come from a parallel input bus (test pattern generator, loopback, or host registers).
- Used for hardware-in-the-loop testing of the line-sensor path without physical sensors.

Parameters:
- DATA_WIDTH, 12: conversion result width.
- NUM_CH, 8: number of emulated channels.
- ADDR_W, 3: channel address width.
- SYNC_STAGES, 2: synchronizer depth on cs_n/sclk/mosi.

Ports:
- clock_in  input  1: system clock (50 MHz); must be at least 8x the SCLK frequency.
- reset  input  1: asynchronous, active-low reset.
- adc_chip_enable  input  1: active-low chip select from the master.
- adc_serial_clk  input  1: SCLK from the master; idle low.
- mosi  input  1: DIN from the master.
- ch_value  input  NUM_CH*DATA_WIDTH: channel n occupies bits [n*12+11 : n*12].
- miso  output  1: DOUT to the master.
- addr_captured  output  ADDR_W: address received in the last completed frame.
- frame_done  output  1: single-cycle pulse per completed 16-clock frame.

Behaviour:
Interface clocking and reset
- reset asynchronous and active-low; clock_in single clock domain.
- On reset: miso=0, addr_captured=0, frame_done=0, bit counter=0, current channel=0, shift register=0.

Input synchronization and edge detection
- cs_n, sclk and mosi pass through SYNC_STAGES flops.
- Rise/fall of sclk is detected from registered synchronized samples.
- Latency from a pin edge to the internal edge strobe is SYNC_STAGES+1 clock_in cycles.

Frame sequencing
- Frame starts on cs_n falling.
- Bit counter (4 bits) counts SCLK rising edges 1..16 within the frame.

Address capture (rising edges)
- Edges 3, 4 and 5 shift mosi into the address register as ADD2, ADD1, ADD0.
- All other rising edges ignore mosi.

Data output (falling edges)
- Falling edge after rising edge k updates miso for clock k+1.
- Clocks 1-4 output 0.
- Falling edge 4 loads the shift register from ch_value[current channel]; miso=DB11.
- Falling edges 5..15 shift out DB10..DB0.
- Falling edge 16 sets miso=0 (leading zero of the next frame).
- Clock 1's zero is driven from cs_n fall.
- miso updates within SYNC_STAGES+1 cycles of the SCLK falling edge.

Frame completion (rising edge 16)
- current channel <= captured address.
- addr_captured <= captured address.
- frame_done pulses 1 cycle.
- Counter wraps to 0; back-to-back frames with cs_n held low continue seamlessly.

Channel pipelining
- Data in frame N is for the address received in frame N-1.
- First frame after cs_n falls returns channel 0.

Boundary conditions
- cs_n rises mid-frame: abort; counter=0, miso=0, partial address discarded, current channel=0, no frame_done.
- cs_n high: all SCLK edges ignored.
- ch_value changes after falling edge 4: no effect until the next frame's load.
- Simultaneous cs_n rise and SCLK edge in the same cycle: cs_n wins.
- Address values are all legal (3 bits, 8 channels).

State machine
- IDLE (cs_n high) -> ACTIVE on cs_n fall.
- ACTIVE -> IDLE on cs_n rise.
- Counter wrap stays in ACTIVE.

Optional Feature:
- ADC_RESP_TRISTATE_EN defined: miso is 1'bz whenever synchronized cs_n is high, matching the real ADC's high-impedance DOUT. Reset also drives z.
- Not defined: miso is driven 0 when deselected.
- All other behaviour is identical either way.

Decomposition:
- Package adc_spi_pkg holds:
  - FRAME_BITS=16, ADDR_FIRST_EDGE=3, ADDR_LAST_EDGE=5, DATA_LOAD_FALL=4, ADC_RES=12.
  - typedef adc_word_t (12-bit) and adc_chan_t (3-bit).
- One sub-module: spi_sync_edge (parameterized synchronizer plus rise/fall strobe generator), instantiated for sclk and cs_n; mosi uses the synchronizer only.

Test Plan:
1. Reset asserted mid-frame -> miso=0 (z with ADC_RESP_TRISTATE_EN), addr_captured=0, frame_done=0 within 1 cycle; counter restarts on the next cs_n fall.
2. cs_n low; frame 1 address 3'b101; ch_value ch0=12'hA5C, ch5=12'h3F1 -> frame 1 MISO bits 16'h0A5C, frame 2 bits 16'h03F1, addr_captured=5 after frame 1.
3. Eight back-to-back frames at 1.5625 MHz SCLK, cs_n held low, addresses 0..7, ch_value[n]=n*12'h111 -> frame k+1 returns (k)*12'h111; 8 frame_done pulses, no bit slip.
4. cs_n rises after rising edge 4 with address bits 1,1 -> no frame_done; next frame returns ch0; addr_captured unchanged.
5. ch_value[0] changed from 12'h000 to 12'hFFF between falling edges 4 and 5 -> current frame returns 12'h000; next frame returns 12'hFFF.
6. SCLK at clock_in/8 (6.25 MHz) with master sampling on the rising edge -> all 12 bits correct; miso changes no later than 3 clock_in cycles after the SCLK fall.
